// File: rtl/cpu_pkg.sv
// Shared opcodes, function codes, FSM states and ALU controls
// for the multi-cycle MIPS-subset core.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5
  } alu_t;

endpackage

// File: rtl/cpu_regfile.sv
// 32-entry register file: two async read ports, one sync write port.
// R0 is never written, so it always reads zero.
module cpu_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: fetch/decode/execute/memory/writeback
// over one unified req/ack memory port.
module multi_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o,
  output logic              illegal_o
);

  state_t            state;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] a, b, alu_out, mdr;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign imm   = ir[15:0];

  logic [DATA_W-1:0] sext_imm;
  logic [ADDR_W-1:0] br_off;
  assign sext_imm = {{(DATA_W-16){imm[15]}}, imm};
  assign br_off   = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};

  logic is_r;
  assign is_r = (op == OP_RTYPE);

  alu_t ctl;
  logic legal;

  always_comb begin
    ctl   = ALU_ADD;
    legal = 1'b1;
    unique case (1'b1)
      is_r && funct == FN_ADD: ctl = ALU_ADD;
      is_r && funct == FN_SUB: ctl = ALU_SUB;
      is_r && funct == FN_AND: ctl = ALU_AND;
      is_r && funct == FN_OR:  ctl = ALU_OR;
      is_r && funct == FN_SLT: ctl = ALU_SLT;
      is_r && funct == FN_SLL: ctl = ALU_SLL;
      op == OP_ADDI, op == OP_LW, op == OP_SW,
      op == OP_BEQ, op == OP_BNE, op == OP_HALT:
        ctl = ALU_ADD;
      default: legal = 1'b0;
    endcase
  end

  logic [DATA_W-1:0] opb, alu_y;
  assign opb = is_r ? b : sext_imm;

  always_comb begin
    alu_y = '0;
    unique case (ctl)
      ALU_ADD: alu_y = a + opb;
      ALU_SUB: alu_y = a - opb;
      ALU_AND: alu_y = a & opb;
      ALU_OR:  alu_y = a | opb;
      ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(opb)};
      ALU_SLL: alu_y = b << shamt;
      default: alu_y = '0;
    endcase
  end

  logic taken;
  assign taken = (op == OP_BEQ) ? (a == b) : (a != b);

  logic [DATA_W-1:0] rd1, rd2, wd;
  logic [4:0]        wa;
  logic              rf_we;

  assign rf_we = (state == ST_WB);
  assign wa    = is_r ? rd : rt;
  assign wd    = (op == OP_LW) ? mdr : alu_out;

  cpu_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk (clk_i),
    .rst (rst_i),
    .ra1 (rs),
    .ra2 (rt),
    .we  (rf_we),
    .wa  (wa),
    .wd  (wd),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_FETCH;
      ir          <= '0;
      pc          <= PC_RESET;
      target      <= '0;
      a           <= '0;
      b           <= '0;
      alu_out     <= '0;
      mdr         <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      halted_o    <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (!mem_req_o) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= pc;
          end else if (mem_ack_i) begin
            ir        <= mem_rdata_i[31:0];
            pc        <= pc + ADDR_W'(4);
            mem_req_o <= 1'b0;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a      <= rd1;
          b      <= rd2;
          target <= pc + br_off;
          if (!legal) begin
            illegal_o <= 1'b1;
            halted_o  <= 1'b1;
            state     <= ST_HALT;
          end else if (op == OP_HALT) begin
            halted_o <= 1'b1;
            state    <= ST_HALT;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_out <= alu_y;
          unique case (1'b1)
            op == OP_LW, op == OP_SW: begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= (op == OP_SW);
              mem_addr_o  <= alu_y[ADDR_W-1:0];
              mem_wdata_o <= b;
              state       <= ST_MEM;
            end
            op == OP_BEQ, op == OP_BNE: begin
              // next fetch is issued here so a branch costs 3 cycles
              if (taken) pc <= target;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= taken ? target : pc;
              state      <= ST_FETCH;
            end
            default: state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ack_i) begin
            mdr <= mem_rdata_i;
            if (mem_we_o) begin
              mem_we_o   <= 1'b0;
              mem_addr_o <= pc;
              state      <= ST_FETCH;
            end else begin
              mem_req_o <= 1'b0;
              state     <= ST_WB;
            end
          end
        end
        ST_WB: begin
          mem_req_o  <= 1'b1;
          mem_we_o   <= 1'b0;
          mem_addr_o <= pc;
          state      <= ST_FETCH;
        end
        ST_HALT: mem_req_o <= 1'b0;
        default: state <= ST_HALT;
      endcase
    end
  end

  assign pc_o = pc;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Randomized self-checking bench for multi_cycle_cpu against an
// instruction-level reference interpreter.
module tb_multi_cycle_cpu;

  localparam logic [31:0] PCR = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [31:0] pc;
  logic        halted, illegal;

  always #5 clk = ~clk;

  multi_cycle_cpu #(
    .DATA_W(32), .ADDR_W(32), .PC_RESET(PCR)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .pc_o        (pc),
    .halted_o    (halted),
    .illegal_o   (illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] ram  [1024];
  logic [31:0] mref [1024];
  logic [31:0] rref [32];
  int          wait_n   = 0;
  bit          block_wr = 1'b0;
  int          cnt      = 0;
  int          cyc      = 0;
  int          fa [$];
  logic [31:0] t_addr, t_wd;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // memory model: ack after wait_n idle cycles, writes land at ack
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (mem_req) begin
      if (cnt == 0) begin
        t_addr = mem_addr;
        t_wd   = mem_wdata;
      end
      if (cnt >= wait_n && !(block_wr && mem_we)) begin
        if (cnt > 0) begin
          check("stable_addr", mem_addr, t_addr);
          if (mem_we) check("stable_wdata", mem_wdata, t_wd);
        end
        mem_ack   = 1'b1;
        mem_rdata = ram[mem_addr[11:2]];
        if (mem_we) ram[mem_addr[11:2]] = mem_wdata;
        if (!mem_we && mem_addr >= 32'h100 && mem_addr < 32'h200)
          fa.push_back(cyc);
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      cnt = 0;
    end
  end

  function automatic logic [31:0] r_ins(input int fn, input int s,
                                        input int t, input int d,
                                        input int sh);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int s,
                                        input int t,
                                        input logic [15:0] im);
    return {6'(op), 5'(s), 5'(t), im};
  endfunction

  // instruction-level interpreter over mref/rref
  task automatic model_run(input int w, output int ce,
                           output logic [31:0] pe, output bit ie);
    logic [31:0] p, ins, va, vb, sx, ea, res;
    logic [5:0]  op, fn;
    int          s, t, d, sh;
    bit          stop;
    for (int i = 0; i < 32; i++) rref[i] = '0;
    p = PCR; ce = 1; ie = 0; stop = 0;
    for (int k = 0; k < 2000 && !stop; k++) begin
      ins = mref[p[11:2]];
      p   = p + 4;
      ce += 1 + w;
      op = ins[31:26]; fn = ins[5:0];
      s = int'(ins[25:21]); t = int'(ins[20:16]);
      d = int'(ins[15:11]); sh = int'(ins[10:6]);
      sx = {{16{ins[15]}}, ins[15:0]};
      va = rref[s]; vb = rref[t];
      if (op == 6'h00) begin
        res = '0;
        case (fn)
          6'h20: res = va + vb;
          6'h22: res = va - vb;
          6'h24: res = va & vb;
          6'h25: res = va | vb;
          6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          6'h00: res = vb << sh;
          default: begin ie = 1; stop = 1; end
        endcase
        if (stop) ce += 1;
        else begin
          rref[d] = res;
          ce += 3;
        end
      end else begin
        case (op)
          6'h08: begin rref[t] = va + sx; ce += 3; end
          6'h23: begin
            ea = va + sx;
            rref[t] = mref[ea[11:2]];
            ce += 3 + (1 + w);
          end
          6'h2B: begin
            ea = va + sx;
            mref[ea[11:2]] = vb;
            ce += 2 + (1 + w);
          end
          6'h04: begin if (va == vb) p = p + (sx << 2); ce += 2; end
          6'h05: begin if (va != vb) p = p + (sx << 2); ce += 2; end
          6'h3F: begin stop = 1; ce += 1; end
          default: begin ie = 1; stop = 1; ce += 1; end
        endcase
      end
      rref[0] = '0;
    end
    pe = p;
  endtask

  task automatic run_prog(input string nm, input int w);
    int          ce, idle;
    logic [31:0] pe;
    bit          ie, done;
    for (int i = 0; i < 1024; i++) mref[i] = ram[i];
    model_run(w, ce, pe, ie);
    wait_n = w;
    fa.delete();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    done = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      @(negedge clk);
      if (halted) done = 1;
    end
    check({nm, ":halted"}, 32'(done), 32'd1);
    check({nm, ":cycles"}, 32'(cyc), 32'(ce));
    check({nm, ":illegal"}, 32'(illegal), 32'(ie));
    check({nm, ":pc"}, pc, pe);
    for (int r = 0; r < 32; r++)
      check($sformatf("%s:r%0d", nm, r), dut.u_rf.regs[r], rref[r]);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s:dmem%0d", nm, i), ram[512+i], mref[512+i]);
    check({nm, ":dmem8"}, ram[2], mref[2]);
    idle = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) idle++;
    end
    check({nm, ":no_req_halted"}, 32'(idle), 32'd0);
  endtask

  task automatic gen_prog(input int n, input bit end_ill);
    int k, mx, op;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 16; i++) ram[512+i] = $urandom;
    for (int i = 0; i < 7; i++)
      ram[64+i] = i_ins(8, 0, i + 1, 16'($urandom));
    for (int i = 7; i < n - 1; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: ram[64+i] = r_ins(32'h20, $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), 0);
        1: ram[64+i] = r_ins(32'h22, $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), 0);
        2: ram[64+i] = r_ins(32'h24, $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), 0);
        3: ram[64+i] = r_ins(32'h25, $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), 0);
        4: ram[64+i] = r_ins(32'h2A, $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), 0);
        5: ram[64+i] = r_ins(32'h00, 0, $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,31));
        6: ram[64+i] = i_ins(8, $urandom_range(0,7), $urandom_range(0,7), 16'($urandom));
        7: ram[64+i] = i_ins(32'h23, 0, $urandom_range(0,7), 16'(32'h800 + 4 * $urandom_range(0,15)));
        8: ram[64+i] = i_ins(32'h2B, 0, $urandom_range(0,7), 16'(32'h800 + 4 * $urandom_range(0,15)));
        default: begin
          mx = n - 2 - i;
          if (mx > 3) mx = 3;
          op = ($urandom_range(0,1) == 1) ? 4 : 5;
          ram[64+i] = i_ins(op, $urandom_range(0,7), $urandom_range(0,7), 16'($urandom_range(0, mx)));
        end
      endcase
    end
    if (!end_ill) ram[64+n-1] = 32'hFC00_0000;
    else if ($urandom_range(0,1) == 1) ram[64+n-1] = 32'hF800_0000;
    else ram[64+n-1] = r_ins(32'h21, 1, 2, 3, 0);
  endtask

  task automatic load_directed();
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[64] = i_ins(8, 0, 1, 16'd5);
    ram[65] = i_ins(8, 0, 2, 16'hFFFD);
    ram[66] = r_ins(32'h20, 1, 2, 3, 0);
    ram[67] = r_ins(32'h2A, 2, 1, 4, 0);
    ram[68] = r_ins(32'h22, 2, 1, 5, 0);
    ram[69] = i_ins(8, 1, 0, 16'd7);
    ram[70] = i_ins(32'h2B, 0, 1, 16'd8);
    ram[71] = i_ins(32'h23, 0, 6, 16'd8);
    ram[72] = i_ins(4, 1, 1, 16'd2);
    ram[73] = i_ins(8, 0, 7, 16'd99);
    ram[74] = i_ins(8, 0, 7, 16'd99);
    ram[75] = i_ins(5, 1, 1, 16'd5);
    ram[76] = r_ins(32'h20, 6, 1, 8, 0);
    ram[77] = 32'hFC00_0000;
  endtask

  int base [11] = '{4, 4, 4, 4, 4, 4, 4, 5, 3, 3, 4};
  int mems [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
  int fetch_at [12] = '{64, 65, 66, 67, 68, 69, 70, 71, 72, 75, 76, 77};

  initial begin
    int seen;
    for (int i = 0; i < 1024; i++) ram[i] = '0;

    // reset state and first fetch
    repeat (3) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_pc", pc, PCR);
    check("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, PCR);
    check("first_we", 32'(mem_we), 32'd0);

    // directed sequence at zero-wait and with 3 wait states
    for (int w = 0; w <= 3; w += 3) begin
      load_directed();
      run_prog($sformatf("dir_w%0d", w), w);
      check("dir_r3", dut.u_rf.regs[3], 32'd2);
      check("dir_r4", dut.u_rf.regs[4], 32'd1);
      check("dir_r5", dut.u_rf.regs[5], 32'hFFFF_FFF8);
      check("dir_r6", dut.u_rf.regs[6], 32'd5);
      check("dir_r7", dut.u_rf.regs[7], 32'd0);
      check("dir_r8", dut.u_rf.regs[8], 32'd10);
      check("dir_mem8", ram[2], 32'd5);
      check("dir_nfetch", 32'(fa.size()), 32'd12);
      if (fa.size() == 12)
        for (int i = 0; i < 11; i++)
          check($sformatf("dir_w%0d_cyc%0d", w, fetch_at[i]),
                32'(fa[i+1] - fa[i]), 32'(base[i] + w * (1 + mems[i])));
    end

    // random programs, random wait states, some ending illegal
    for (int t = 0; t < 8; t++) begin
      gen_prog(30, t[0]);
      run_prog($sformatf("rnd%0d", t), $urandom_range(0, 2));
    end

    // reset while a store is pending
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[2]  = 32'hDEAD_0000;
    ram[64] = i_ins(8, 0, 1, 16'd5);
    ram[65] = i_ins(32'h2B, 0, 1, 16'd8);
    ram[66] = 32'hFC00_0000;
    block_wr = 1'b1;
    wait_n = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && seen == 0; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) seen = 1;
    end
    check("mid_sw_seen", 32'(seen), 32'd1);
    check("mid_sw_addr", mem_addr, 32'd8);
    check("mid_sw_wdata", mem_wdata, 32'd5);
    check("mid_r1_before", dut.u_rf.regs[1], 32'd5);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_req_drop", 32'(mem_req), 32'd0);
    check("mid_pc", pc, PCR);
    @(negedge clk);
    check("mid_mem_untouched", ram[2], 32'hDEAD_0000);
    check("mid_r1_cleared", dut.u_rf.regs[1], 32'd0);
    block_wr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("mid_refetch_req", 32'(mem_req), 32'd1);
    check("mid_refetch_addr", mem_addr, PCR);
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      @(negedge clk);
      if (halted) seen = 1;
    end
    check("mid_rerun_halt", 32'(seen), 32'd1);
    check("mid_rerun_mem", ram[2], 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_cpu.md
Name: multi_cycle_cpu

Overview:
- Parametrised multi-cycle successor of the single-cycle CPU core.
- Executes the MIPS-subset ISA through an FSM (fetch/decode/execute/memory/writeback) against one unified memory port with a req/ack handshake, so memory may stall.
- Adds load/store, bne, a halt instruction and illegal-opcode trapping, none of which the single-cycle core has.
- Sits at CPU top level; the testbench or memory model drives the memory port.

Parameters:
- DATA_W, 32, datapath/register width; must be >=32. Instructions are always 32 bits, in the low 32 bits of mem_rdata_i.
- ADDR_W, 32, memory address and PC width.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- mem_req_o  out  1  memory request; held until ack.
- mem_we_o  out  1  1 = write (sw), 0 = read (fetch/lw).
- mem_addr_o  out  ADDR_W  byte address.
- mem_wdata_o  out  DATA_W  store data.
- mem_rdata_i  in  DATA_W  read data, valid in the ack cycle.
- mem_ack_i  in  1  transfer complete; sampled only while mem_req_o=1.
- pc_o  out  ADDR_W  current PC (debug).
- halted_o  out  1  core stopped.
- illegal_o  out  1  stopped on an undefined opcode/funct.

Behaviour:
- Reset (async, while rst_i=1):
  - PC=PC_RESET, state=FETCH, all registers=0, IR=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, halted_o=0, illegal_o=0.
  - First request is issued in the first clock after rst_i falls.
  - Reset mid-transfer abandons the transfer; no register or PC update.
- Handshake:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered and stay stable while mem_req_o=1.
  - A transfer completes on the rising edge where mem_req_o=1 and mem_ack_i=1; mem_req_o drops the following cycle.
  - Zero-wait memory (ack in the first req cycle) gives 1 cycle per access; every extra cycle without ack adds 1 cycle.
  - mem_ack_i while mem_req_o=0 is ignored.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: req read at PC. On ack: IR<=rdata[31:0], PC<=PC+4 (mod 2^ADDR_W), go to DECODE.
  - DECODE: A<=R[rs], B<=R[rt], target<=PC+(sext(imm)<<2). Undefined opcode/funct -> HALT with illegal_o=1. Opcode 0x3F -> HALT with illegal_o=0. Otherwise go to EXEC.
  - EXEC:
    - R-type: ALUout<=A op B, then WB.
    - addi/lw/sw: ALUout<=A+sext(imm); addi goes to WB, lw/sw go to MEM.
    - beq/bne: if the condition holds, PC<=target; then FETCH.
  - MEM: lw issues a read, sw issues a write with wdata=B, both at ALUout[ADDR_W-1:0]. On ack: lw latches MDR and goes to WB; sw goes to FETCH.
  - WB: R[dest]<=ALUout or MDR, then FETCH. dest=rd for R-type, rt otherwise.
  - HALT: absorbing; halted_o=1; no further requests. Only reset exits.
- Cycles at zero-wait memory: R/addi 4, lw 5, sw 4, beq/bne 3, halt 2.
- ISA decode:
  - op 0 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x00 sll (uses shamt).
  - op 0x08 addi, 0x04 beq, 0x05 bne, 0x23 lw, 0x2B sw, 0x3F halt. Everything else is illegal.
- Arithmetic:
  - DATA_W two's complement; add/sub wrap silently (no overflow trap).
  - slt is a signed compare, result 1 or 0, zero-extended.
  - Immediates are sign-extended from 16 bits to DATA_W.
- Register file:
  - 32 entries of DATA_W; R0 always reads 0, and writes to it are discarded.
  - Written only in WB.
  - Reads are combinational; a WB followed by the next instruction's DECODE sees the new value (a different cycle, so no bypass is needed).
- Addresses are not alignment-checked; the low 2 bits are passed through.

Decomposition:
- Package cpu_pkg:
  - opcode and funct localparams;
  - state encoding (3 bits: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5);
  - ALU control codes (4 bits).
- Sub-module cpu_regfile (parameter DATA_W): 2 async read ports, 1 sync write port, R0 hardwired to zero.
- The ALU is inline combinational logic in the core.

Test Plan:
- Reset/first fetch: rst_i=1 for 3 cycles, then released with PC_RESET=0x100 -> mem_req_o=0 during reset; next cycle mem_req_o=1, mem_addr_o=0x100, mem_we_o=0.
- ALU sequence, zero-wait: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sub $5,$2,$1 -> R3=2, R4=1, R5=-8 (0xFFFFFFF8); each instruction takes exactly 4 cycles; writes to $0 leave it reading 0.
- Load/store with wait states: memory acks after 3 extra cycles; sw $1,8($0) then lw $6,8($0) -> write at addr 8 with wdata=5, address/data stable through the stall; R6=5; lw takes 5+3+3 cycles.
- Branches: beq taken at 0x10 with imm=2 -> next fetch at 0x1C; bne not taken -> next fetch at 0x14; each takes 3 cycles; no register written.
- Halt/illegal: op 0x3F -> halted_o=1, illegal_o=0, no further mem_req_o for 20 cycles; op 0x3E -> halted_o=1, illegal_o=1; asserting rst_i restarts fetch at PC_RESET.
- Reset mid-MEM: assert rst_i while an sw request is pending -> mem_req_o drops immediately (async); memory is not written; after release, fetch restarts at PC_RESET and all registers are 0.
